// File: rtl/geofence_pkg.sv
// Shared types and constants for the geofence job scheduler.
//   state_e     : scheduler FSM states
//   NPTS        : points per job (target + 6 fence vertices)
//   DEF_CW      : default coordinate width
//   DEF_TIMEOUT : default engine wait limit in cycles
package geofence_pkg;

  localparam int unsigned NPTS        = 7;
  localparam int unsigned DEF_CW      = 10;
  localparam int unsigned DEF_TIMEOUT = 64;

  typedef enum logic [2:0] {
    StIdle,
    StBoot,
    StStream,
    StWait,
    StDone
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, purely combinational.
//   req   : request vector
//   ptr   : index where the search starts (highest priority)
//   grant : one-hot grant to the first requester found at or after ptr, zero if none
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = (32'(ptr) + off) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/geofence_sched.sv
// Shares one geofence engine among NREQ requesters. A job resets the engine, streams the
// owner's 7 points (target then 6 vertices), waits for the verdict (bounded by TIMEOUT)
// and reports it with a one-cycle strobe.
//   clk, reset            : clock, asynchronous active-low reset
//   req                   : per-requester job request (level)
//   req_x, req_y          : per-requester point buses, slice i for the current pt_idx
//   gnt                   : one-hot owner grant, only while streaming
//   pt_idx                : point index being fetched
//   eng_reset             : active-high engine reset (high while idle)
//   eng_x, eng_y          : registered point fed to the engine
//   eng_valid, eng_inside : engine result strobe and verdict
//   res_valid, res_id     : result strobe and owner index
//   res_inside, res_err   : verdict and timeout flag
//   busy                  : a job is in progress
module geofence_sched
  import geofence_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned CW      = DEF_CW,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  localparam int unsigned IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*CW-1:0] req_x,
  input  logic [NREQ*CW-1:0] req_y,
  output logic [NREQ-1:0]  gnt,
  output logic [2:0]       pt_idx,
  output logic             eng_reset,
  output logic [CW-1:0]    eng_x,
  output logic [CW-1:0]    eng_y,
  input  logic             eng_valid,
  input  logic             eng_inside,
  output logic             res_valid,
  output logic [IW-1:0]    res_id,
  output logic             res_inside,
  output logic             res_err,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;

  state_e          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [2:0]      pt_q, pt_d;
  logic [CW-1:0]   ex_q, ex_d, ey_q, ey_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            inside_q, inside_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .grant (arb_gnt)
  );

  always_comb begin
    arb_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) arb_idx = IW'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    pt_d     = pt_q;
    ex_d     = ex_q;
    ey_d     = ey_q;
    cnt_d    = cnt_q;
    inside_d = inside_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          owner_d = arb_idx;
          ptr_d   = (32'(arb_idx) == NREQ - 1) ? '0 : arb_idx + IW'(1);
          state_d = StBoot;
        end
      end
      StBoot: begin
        pt_d    = '0;
        state_d = StStream;
      end
      StStream: begin
        // Point pt_q is on the owner's bus now; the engine sees it next cycle.
        ex_d = req_x[owner_q*CW +: CW];
        ey_d = req_y[owner_q*CW +: CW];
        if (pt_q == 3'(NPTS - 1)) begin
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          pt_d = pt_q + 3'd1;
        end
      end
      StWait: begin
        // A verdict arriving on the last allowed cycle beats the timeout.
        if (eng_valid) begin
          inside_d = eng_inside;
          err_d    = 1'b0;
          state_d  = StDone;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          inside_d = 1'b0;
          err_d    = 1'b1;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      ptr_q    <= '0;
      pt_q     <= '0;
      ex_q     <= '0;
      ey_q     <= '0;
      cnt_q    <= '0;
      inside_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      pt_q     <= pt_d;
      ex_q     <= ex_d;
      ey_q     <= ey_d;
      cnt_q    <= cnt_d;
      inside_q <= inside_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    gnt = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      gnt[i] = (state_q == StStream) && (owner_q == IW'(i));
    end
  end

  assign pt_idx     = pt_q;
  assign eng_x      = ex_q;
  assign eng_y      = ey_q;
  assign eng_reset  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign res_valid  = (state_q == StDone);
  assign res_id     = res_valid ? owner_q : '0;
  assign res_inside = res_valid & inside_q;
  assign res_err    = res_valid & err_q;

endmodule
